// File: rtl/bp_halt_ctrl.sv
// bp_halt_ctrl: debug run-control sequencer.
// Halts the CPU on a PC breakpoint match or a manual halt request.
// Also supports single-step and resume-past-breakpoint.
module bp_halt_ctrl #(
  parameter logic        START_HALTED = 1'b0,
  parameter logic [15:0] NO_BP_ADDR   = 16'hffff
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_pc,
  input  logic        instr_bound,
  input  logic [15:0] bp_addr,
  input  logic        bp_enable,
  input  logic        btn_halt,
  input  logic        btn_step,
  input  logic        btn_run,
  output logic        cpu_halt,
  output logic        bp_hit,
  output logic [7:0]  hit_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  localparam state_t RST_STATE = START_HALTED ? S_HALTED : S_RUN;

  state_t     state, state_nxt;
  logic       step_armed, armed_nxt;
  logic       hit_nxt;
  logic [7:0] cnt_nxt;
  logic       match;

  // The all-ones sentinel address can never match, even when the PC reaches it.
  assign match = bp_enable & instr_bound & (cpu_pc == bp_addr) & (bp_addr != NO_BP_ADDR);

  assign dbg_state = state;

  // State and status registers. Reset overrides any buttons pending in that cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= RST_STATE;
      step_armed <= 1'b0;
      bp_hit     <= 1'b0;
      hit_count  <= 8'd0;
    end else begin
      state      <= state_nxt;
      step_armed <= armed_nxt;
      bp_hit     <= hit_nxt;
      hit_count  <= cnt_nxt;
    end
  end

  // Next-state logic and the combinational halt output.
  // The halt is raised in the same cycle as a match, so the instruction at bp_addr never starts.
  always_comb begin
    state_nxt = state;
    armed_nxt = step_armed;
    hit_nxt   = bp_hit;
    cnt_nxt   = hit_count;
    cpu_halt  = 1'b0;
    unique case (state)
      S_RUN: begin
        cpu_halt = match;
        if (match) begin
          state_nxt = S_HALTED;
          hit_nxt   = 1'b1;
          cnt_nxt   = (hit_count == 8'hff) ? hit_count : hit_count + 8'd1;
        end else if (btn_halt) begin
          state_nxt = S_HALTED;
          hit_nxt   = 1'b0;
        end
      end
      S_HALTED: begin
        cpu_halt = 1'b1;
        if (btn_step) begin
          state_nxt = S_STEP;
          armed_nxt = 1'b0;
          hit_nxt   = 1'b0;
        end else if (btn_run) begin
          state_nxt = S_RESUME;
          hit_nxt   = 1'b0;
        end
      end
      S_STEP: begin
        // The first STEP cycle releases the held boundary.
        // The next boundary reached is halted, so exactly one instruction executes.
        cpu_halt  = step_armed & instr_bound;
        armed_nxt = 1'b1;
        if (btn_halt || (step_armed && instr_bound))
          state_nxt = S_HALTED;
      end
      S_RESUME: begin
        // Match checking is suppressed for one cycle so the core can leave bp_addr.
        cpu_halt  = 1'b0;
        state_nxt = btn_halt ? S_HALTED : S_RUN;
      end
      default: state_nxt = RST_STATE;
    endcase
  end

endmodule

// File: tb/tb_bp_halt_ctrl.sv
// Directed self-checking bench for bp_halt_ctrl (START_HALTED = 0).
module tb_bp_halt_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] cpu_pc;
  logic        instr_bound;
  logic [15:0] bp_addr;
  logic        bp_enable;
  logic        btn_halt, btn_step, btn_run;
  logic        cpu_halt, bp_hit;
  logic [7:0]  hit_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int passed = 0;

  bp_halt_ctrl dut (
    .clock(clock), .reset(reset), .cpu_pc(cpu_pc), .instr_bound(instr_bound),
    .bp_addr(bp_addr), .bp_enable(bp_enable), .btn_halt(btn_halt),
    .btn_step(btn_step), .btn_run(btn_run), .cpu_halt(cpu_halt),
    .bp_hit(bp_hit), .hit_count(hit_count), .dbg_state(dbg_state)
  );

  always #5 clock = ~clock;

  // Apply one cycle of inputs and let the combinational outputs settle.
  task automatic drive(input logic [15:0] pc, input logic bnd, input logic h,
                       input logic s, input logic r);
    cpu_pc = pc; instr_bound = bnd; btn_halt = h; btn_step = s; btn_run = r;
    #1;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; bp_addr = 16'h0150; bp_enable = 1'b1;
    drive(16'h0100, 1'b0, 1'b1, 1'b0, 1'b0);
    tick; tick;
    reset = 1'b1;
    drive(16'h0100, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else passed++;
    checks++; if (cpu_halt !== 1'b0) $display("FAIL reset_halt got %b want 0", cpu_halt); else passed++;
    checks++; if (bp_hit !== 1'b0 || hit_count !== 8'd0)
      $display("FAIL reset_status got hit=%b cnt=%0d want 0/0", bp_hit, hit_count); else passed++;
  endtask

  task automatic test_bp_hit;
    int bad = 0;
    for (int p = 16'h0100; p < 16'h0150; p++) begin
      drive(p[15:0], 1'b1, 1'b0, 1'b0, 1'b0);
      if (cpu_halt !== 1'b0 || dbg_state !== 2'd0) bad++;
      tick;
    end
    checks++; if (bad != 0) $display("FAIL sweep_no_halt got %0d bad cycles want 0", bad); else passed++;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cpu_halt !== 1'b1) $display("FAIL match_halt got %b want 1", cpu_halt); else passed++;
    tick;
    checks++; if (dbg_state !== 2'd1 || bp_hit !== 1'b1 || hit_count !== 8'd1)
      $display("FAIL hit1 got st=%0d hit=%b cnt=%0d want 1/1/1", dbg_state, bp_hit, hit_count); else passed++;
  endtask

  task automatic test_resume;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (cpu_halt !== 1'b1) $display("FAIL halted_halt got %b want 1", cpu_halt); else passed++;
    tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd3 || cpu_halt !== 1'b0 || bp_hit !== 1'b0)
      $display("FAIL resume_cycle got st=%0d halt=%b hit=%b want 3/0/0", dbg_state, cpu_halt, bp_hit); else passed++;
    tick;
    drive(16'h0151, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd0 || cpu_halt !== 1'b0)
      $display("FAIL resume_to_run got st=%0d halt=%b want 0/0", dbg_state, cpu_halt); else passed++;
    tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cpu_halt !== 1'b1) $display("FAIL rehit_halt got %b want 1", cpu_halt); else passed++;
    tick;
    checks++; if (dbg_state !== 2'd1 || bp_hit !== 1'b1 || hit_count !== 8'd2)
      $display("FAIL hit2 got st=%0d hit=%b cnt=%0d want 1/1/2", dbg_state, bp_hit, hit_count); else passed++;
  endtask

  task automatic test_step;
    drive(16'h0150, 1'b1, 1'b0, 1'b1, 1'b0);
    tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd2 || cpu_halt !== 1'b0 || bp_hit !== 1'b0)
      $display("FAIL step_first got st=%0d halt=%b hit=%b want 2/0/0", dbg_state, cpu_halt, bp_hit); else passed++;
    tick;
    drive(16'h0151, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd2 || cpu_halt !== 1'b0)
      $display("FAIL step_wait got st=%0d halt=%b want 2/0", dbg_state, cpu_halt); else passed++;
    tick;
    drive(16'h0151, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cpu_halt !== 1'b1) $display("FAIL step_halt got %b want 1", cpu_halt); else passed++;
    tick;
    checks++; if (dbg_state !== 2'd1 || bp_hit !== 1'b0 || hit_count !== 8'd2)
      $display("FAIL step_done got st=%0d hit=%b cnt=%0d want 1/0/2", dbg_state, bp_hit, hit_count); else passed++;
  endtask

  task automatic test_priority;
    drive(16'h0151, 1'b1, 1'b0, 1'b1, 1'b1);
    tick;
    checks++; if (dbg_state !== 2'd2) $display("FAIL step_beats_run got %0d want 2", dbg_state); else passed++;
    drive(16'h0151, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    checks++; if (dbg_state !== 2'd1) $display("FAIL step_halt_btn got %0d want 1", dbg_state); else passed++;
    drive(16'h0151, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    drive(16'h0151, 1'b1, 1'b0, 1'b0, 1'b0); tick;
    drive(16'h0150, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    checks++; if (dbg_state !== 2'd1 || bp_hit !== 1'b1 || hit_count !== 8'd3)
      $display("FAIL match_beats_halt got st=%0d hit=%b cnt=%0d want 1/1/3", dbg_state, bp_hit, hit_count); else passed++;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0); tick;
    drive(16'h0160, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    checks++; if (dbg_state !== 2'd1 || bp_hit !== 1'b0 || hit_count !== 8'd3)
      $display("FAIL manual_halt got st=%0d hit=%b cnt=%0d want 1/0/3", dbg_state, bp_hit, hit_count); else passed++;
  endtask

  task automatic test_back_to_back;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0); tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd0 || cpu_halt !== 1'b1)
      $display("FAIL loop_recatch got st=%0d halt=%b want 0/1", dbg_state, cpu_halt); else passed++;
    tick;
    checks++; if (hit_count !== 8'd4) $display("FAIL loop_count got %0d want 4", hit_count); else passed++;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 251; i++) begin
      drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b1); tick;
      drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0); tick;
      drive(16'h0151, 1'b1, 1'b0, 1'b0, 1'b0); tick;
      drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0); tick;
    end
    checks++; if (hit_count !== 8'hff) $display("FAIL cnt_reach_ff got %0d want 255", hit_count); else passed++;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0); tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0); tick;
    checks++; if (hit_count !== 8'hff || dbg_state !== 2'd1)
      $display("FAIL cnt_saturate got cnt=%0d st=%0d want 255/1", hit_count, dbg_state); else passed++;
    bp_addr = 16'hffff;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b1); tick;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0); tick;
    drive(16'hffff, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cpu_halt !== 1'b0) $display("FAIL no_bp_sentinel got %b want 0", cpu_halt); else passed++;
    tick;
    bp_addr = 16'h0150; bp_enable = 1'b0;
    drive(16'h0150, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (cpu_halt !== 1'b0) $display("FAIL bp_disabled got %b want 0", cpu_halt); else passed++;
    tick;
    checks++; if (dbg_state !== 2'd0) $display("FAIL run_stays got %0d want 0", dbg_state); else passed++;
    bp_enable = 1'b1;
  endtask

  task automatic test_reset_mid_step;
    drive(16'h0200, 1'b1, 1'b1, 1'b0, 1'b0); tick;
    drive(16'h0200, 1'b1, 1'b0, 1'b1, 1'b0); tick;
    drive(16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd2) $display("FAIL pre_reset_step got %0d want 2", dbg_state); else passed++;
    reset = 1'b0;
    drive(16'h0200, 1'b1, 1'b1, 1'b0, 1'b0);
    tick;
    reset = 1'b1;
    drive(16'h0200, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (dbg_state !== 2'd0 || cpu_halt !== 1'b0 || bp_hit !== 1'b0 || hit_count !== 8'd0)
      $display("FAIL reset_mid_step got st=%0d halt=%b hit=%b cnt=%0d want 0/0/0/0",
               dbg_state, cpu_halt, bp_hit, hit_count); else passed++;
  endtask

  initial begin
    test_reset;
    test_bp_hit;
    test_resume;
    test_step;
    test_priority;
    test_back_to_back;
    test_saturate;
    test_reset_mid_step;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
